ppu_issue_ctrl: RTL and testbench

PPU_ISSUE_CTRL -- requirements
Module: ppu_issue_ctrl

---
 rtl/ppu_issue_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_ppu_issue_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_issue_ctrl.sv
// ppu_issue_ctrl
//   Issue controller in front of a combinational posit (ppu) adder.
//   Operand pairs enter a DEPTH-entry FIFO. The head moves into the operand
//   register (OPR), which drives the adder. The adder result is captured in
//   the result register (RES). Subtraction is done by two's-complement
//   negation of B at accept time, so the adder only ever adds.
//
//   Parameters: N (posit width), es (exponent width, used by the attached
//   adder only), DEPTH (FIFO entries, power of 2, >= 2).
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     in_valid/in_ready        operand pair handshake
//     in_a, in_b, in_sub       operands; in_sub=1 selects A-B
//     ppu_in1, ppu_in2         operands to the adder (0 when OPR is empty)
//     ppu_out/inf/zero         adder sum and flags
//     res_valid/res_ready      result handshake
//     res_data/inf/zero        registered result
//     op_count, nar_count      delivered / NaR-delivered counters
//
//   Build option: define PPU_ISSUE_STATS_EN to build the saturating
//   op_count/nar_count counters; otherwise both outputs are tied to 0.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   S_IDLE  | FIFO, OPR and RES all empty
//   S_RUN   | some stage occupied, result path not stalled
//   S_STALL | result held: res_valid & ~res_ready

module ppu_issue_ctrl #(
   parameter int N     = 32,
   parameter int es    = 2,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   input  logic         in_sub,
   output logic [N-1:0] ppu_in1,
   output logic [N-1:0] ppu_in2,
   input  logic [N-1:0] ppu_out,
   input  logic         ppu_inf,
   input  logic         ppu_zero,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [N-1:0] res_data,
   output logic         res_inf,
   output logic         res_zero,
   output logic [15:0]  op_count,
   output logic [15:0]  nar_count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [N-1:0] NAR     = {1'b1, {(N-1){1'b0}}};
   localparam logic [PW:0]  DEPTH_C = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_STALL} state_t;

   state_t         state, state_nxt;

   logic [N-1:0]   fifo_a [DEPTH];
   logic [N-1:0]   fifo_b [DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [PW:0]    fifo_count;

   logic           opr_valid;
   logic [N-1:0]   opr_a, opr_b;

   logic           push, pop, res_adv, res_take, busy_nxt;
   logic [N-1:0]   b_eff;

   // es only configures the attached adder
   logic           unused_es;
   assign unused_es = (es > 0);

   assign in_ready = (fifo_count < DEPTH_C);
   assign push     = in_valid & in_ready;
   assign res_take = res_valid & res_ready;
   assign res_adv  = opr_valid & (~res_valid | res_ready);
   assign pop      = (fifo_count != '0) & (~opr_valid | res_adv);

   // two's-complement negation already maps 0->0 and NaR->NaR
   assign b_eff = in_sub ? (~in_b + N'(1)) : in_b;

   assign ppu_in1 = opr_valid ? opr_a : '0;
   assign ppu_in2 = opr_valid ? opr_b : '0;

   // ---------------- operand FIFO ----------------
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_a[wr_ptr] <= in_a;
         fifo_b[wr_ptr] <= b_eff;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
            2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // ---------------- operand register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         opr_valid <= 1'b0;
         opr_a     <= '0;
         opr_b     <= '0;
      end else if (pop) begin
         opr_valid <= 1'b1;
         opr_a     <= fifo_a[rd_ptr];
         opr_b     <= fifo_b[rd_ptr];
      end else if (res_adv) begin
         opr_valid <= 1'b0;
      end
   end

   // ---------------- result register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_inf   <= 1'b0;
         res_zero  <= 1'b0;
      end else if (res_adv) begin
         res_valid <= 1'b1;
         res_data  <= ppu_inf ? NAR : ppu_out;
         res_inf   <= ppu_inf;
         res_zero  <= ppu_zero;
      end else if (res_take) begin
         res_valid <= 1'b0;
      end
   end

   // ---------------- sequencing FSM ----------------
   // A FIFO entry always lands in OPR and an OPR entry always lands in RES,
   // so the pipeline stays busy unless only RES is left and it is taken.
   assign busy_nxt = push | (fifo_count != '0) | opr_valid | (res_valid & ~res_ready);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (push) state_nxt = S_RUN;
         S_RUN: begin
            if (res_valid & ~res_ready) state_nxt = S_STALL;
            else if (~busy_nxt)         state_nxt = S_IDLE;
         end
         S_STALL: if (res_ready) state_nxt = S_RUN;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------- statistics ----------------
`ifdef PPU_ISSUE_STATS_EN
   logic [15:0] op_cnt_q, nar_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         op_cnt_q  <= '0;
         nar_cnt_q <= '0;
      end else if (res_take) begin
         if (op_cnt_q != 16'hFFFF)             op_cnt_q  <= op_cnt_q + 16'd1;
         if (res_inf && nar_cnt_q != 16'hFFFF) nar_cnt_q <= nar_cnt_q + 16'd1;
      end
   end

   assign op_count  = op_cnt_q;
   assign nar_count = nar_cnt_q;
`else
   assign op_count  = '0;
   assign nar_count = '0;
`endif

endmodule

// File: tb/tb_ppu_issue_ctrl.sv
// Testbench for ppu_issue_ctrl: stand-in combinational adder, queue-based
// reference model of the three storage stages, per-cycle compare process,
// directed scenarios with literal expectations, then randomized traffic.

module tb_ppu_issue_ctrl;

   localparam int N     = 32;
   localparam int DEPTH = 4;
   localparam logic [31:0] NAR = 32'h8000_0000;
   localparam bit STATS =
`ifdef PPU_ISSUE_STATS_EN
      1'b1;
`else
      1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, in_valid, in_sub, res_ready, force_inf;
   logic [31:0] in_a, in_b;
   logic        in_ready, res_valid, res_inf, res_zero, ppu_inf, ppu_zero;
   logic [31:0] ppu_in1, ppu_in2, ppu_out, res_data;
   logic [15:0] op_count, nar_count;

   always #5 clk = ~clk;

   // Stand-in adder: plain integer sum, NaR if either operand is NaR or forced.
   assign ppu_out  = ppu_in1 + ppu_in2;
   assign ppu_inf  = force_inf | (ppu_in1 == NAR) | (ppu_in2 == NAR);
   assign ppu_zero = ~ppu_inf & (ppu_out == 32'd0);

   ppu_issue_ctrl #(.N(N), .es(2), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
      .ppu_in1(ppu_in1), .ppu_in2(ppu_in2),
      .ppu_out(ppu_out), .ppu_inf(ppu_inf), .ppu_zero(ppu_zero),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_inf(res_inf), .res_zero(res_zero),
      .op_count(op_count), .nar_count(nar_count)
   );

   typedef struct packed { logic [31:0] a; logic [31:0] b; } pair_t;
   typedef struct packed { logic [31:0] d; logic inf; logic zero; } res_t;

   pair_t fifo_q[$];
   pair_t opr_q[$];
   res_t  res_q[$];
   int    m_op = 0, m_nar = 0;
   int    pass_cnt = 0, total_cnt = 0;
   bit    chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %08h, expected %08h at t=%0t", name, act, exp, $time);
   endtask

   // Reference model: advance the three stages by one clock edge.
   task automatic model_edge();
      pair_t p;
      res_t  r;
      logic [31:0] s;
      bit hs, adv, load, psh;
      if (rst) begin
         fifo_q.delete(); opr_q.delete(); res_q.delete();
         m_op = 0; m_nar = 0;
         return;
      end
      hs   = (res_q.size() == 1) && res_ready;
      adv  = (opr_q.size() == 1) && (res_q.size() == 0 || res_ready);
      load = (fifo_q.size() > 0) && (opr_q.size() == 0 || adv);
      psh  = in_valid && (fifo_q.size() < DEPTH);
      if (hs) begin
         r = res_q.pop_front();
         if (STATS) begin
            if (m_op < 65535) m_op++;
            if (r.inf && m_nar < 65535) m_nar++;
         end
      end
      if (adv) begin
         p      = opr_q.pop_front();
         s      = p.a + p.b;
         r.inf  = force_inf || (p.a == NAR) || (p.b == NAR);
         r.d    = r.inf ? NAR : s;
         r.zero = !r.inf && (s == 32'd0);
         res_q.push_back(r);
      end
      if (load) opr_q.push_back(fifo_q.pop_front());
      if (psh) begin
         p.a = in_a;
         p.b = in_sub ? (32'd0 - in_b) : in_b;
         fifo_q.push_back(p);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return NAR;
         2:       return 32'h4000_0000;
         default: return $urandom;
      endcase
   endfunction

   // Per-cycle compare against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("in_ready",  32'(in_ready),  32'(fifo_q.size() < DEPTH));
            chk("res_valid", 32'(res_valid), 32'(res_q.size() == 1));
            if (res_q.size() == 1) begin
               chk("res_data", res_data,        res_q[0].d);
               chk("res_inf",  32'(res_inf),    32'(res_q[0].inf));
               chk("res_zero", 32'(res_zero),   32'(res_q[0].zero));
            end
            chk("ppu_in1", ppu_in1, (opr_q.size() == 1) ? opr_q[0].a : 32'd0);
            chk("ppu_in2", ppu_in2, (opr_q.size() == 1) ? opr_q[0].b : 32'd0);
            chk("op_count",  32'(op_count),  32'(m_op));
            chk("nar_count", 32'(nar_count), 32'(m_nar));
         end
      end
   end

   initial begin
      logic [31:0] held;
      int mode;
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
      res_ready = 1'b1; force_inf = 1'b0;
      tick();
      chk_en = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst in_ready",  32'(in_ready),  32'd1);
      chk("rst res_valid", 32'(res_valid), 32'd0);
      chk("rst res_data",  res_data,       32'd0);
      chk("rst res_flags", {30'd0, res_inf, res_zero}, 32'd0);
      chk("rst ppu_in",    ppu_in1 | ppu_in2, 32'd0);
      chk("rst counts",    {op_count, nar_count}, 32'd0);

      // 1.0 + 1.0, latency and operand visibility
      in_valid = 1'b1; in_a = 32'h4000_0000; in_b = 32'h4000_0000; in_sub = 1'b0;
      tick();
      in_valid = 1'b0;
      chk("lat E0 res_valid", 32'(res_valid), 32'd0);
      tick();
      chk("lat E1 ppu_in1",   ppu_in1, 32'h4000_0000);
      chk("lat E1 ppu_in2",   ppu_in2, 32'h4000_0000);
      chk("lat E1 res_valid", 32'(res_valid), 32'd0);
      tick();
      chk("lat E2 res_valid", 32'(res_valid), 32'd1);
      chk("lat E2 res_data",  res_data, 32'h8000_0000);
      chk("lat E2 res_inf",   32'(res_inf), 32'd0);
      tick();

      // 1.0 - 1.0
      in_valid = 1'b1; in_sub = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk("sub ppu_in2", ppu_in2, 32'hC000_0000);
      tick();
      chk("sub res_data", res_data, 32'd0);
      chk("sub res_zero", 32'(res_zero), 32'd1);
      tick();

      // 1.0 - NaR with forced adder NaR
      force_inf = 1'b1; in_valid = 1'b1; in_b = NAR; in_sub = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk("nar ppu_in2", ppu_in2, NAR);
      tick();
      chk("nar res_data", res_data, NAR);
      chk("nar res_inf",  32'(res_inf), 32'd1);
      tick();
      force_inf = 1'b0;
      chk("nar nar_count", 32'(nar_count), STATS ? 32'd1 : 32'd0);
      chk("nar op_count",  32'(op_count),  STATS ? 32'd3 : 32'd0);

      // back-pressure: 6 pairs fill FIFO + OPR + RES
      res_ready = 1'b0; in_valid = 1'b1; in_sub = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_a = rnd_op(); in_b = rnd_op();
         tick();
      end
      in_valid = 1'b0;
      chk("full in_ready", 32'(in_ready), 32'd0);
      held = res_data;
      tick(); tick();
      chk("stall res_data",  res_data, held);
      chk("stall res_valid", 32'(res_valid), 32'd1);
      res_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("drain res_valid", 32'(res_valid), 32'd1);
         tick();
      end
      chk("drained res_valid", 32'(res_valid), 32'd0);

      // reset with pairs in flight; reset wins over a same-cycle accept
      res_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_a = rnd_op(); in_b = rnd_op();
         tick();
      end
      rst = 1'b1; res_ready = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      chk("flush res_valid", 32'(res_valid), 32'd0);
      chk("flush in_ready",  32'(in_ready),  32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("no stale result", 32'(res_valid), 32'd0);
      end

      // randomized traffic with stall phases and rare resets
      mode = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c % 100 == 0) mode = $urandom_range(0, 2);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_a      = rnd_op();
         in_b      = rnd_op();
         in_sub    = $urandom_range(0, 1) == 1;
         res_ready = (mode == 0) ? 1'b1 :
                     (mode == 1) ? ($urandom_range(0, 3) != 0) :
                                   ($urandom_range(0, 3) == 0);
         force_inf = ($urandom_range(0, 15) == 0);
         rst       = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      chk("final op_count",  32'(op_count),  STATS ? 32'(m_op) : 32'd0);
      chk("final nar_count", 32'(nar_count), STATS ? 32'(m_nar) : 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
